// File: rtl/dm_abstract_cmd_ctrl_if.sv
// Abstract-command controller bus: DMI-side command/abstractcs traffic plus
// the hart debug-ROM go/going/done/exception handshake.
interface dm_abstract_cmd_ctrl_if;
   logic        dmactive_i;
   logic        cmd_valid_i;
   logic [31:0] cmd_i;
   logic        autoexec_i;
   logic        busy_access_i;
   logic        cmderr_w1c_valid_i;
   logic [2:0]  cmderr_w1c_i;
   logic        halted_i;
   logic        going_i;
   logic        done_i;
   logic        exception_i;
   logic        go_o;
   logic        busy_o;
   logic [2:0]  cmderr_o;
   logic [31:0] cmd_o;
   logic        cmd_start_o;

   modport slave (
      input  dmactive_i, cmd_valid_i, cmd_i, autoexec_i, busy_access_i,
             cmderr_w1c_valid_i, cmderr_w1c_i, halted_i, going_i, done_i,
             exception_i,
      output go_o, busy_o, cmderr_o, cmd_o, cmd_start_o
   );

   modport master (
      output dmactive_i, cmd_valid_i, cmd_i, autoexec_i, busy_access_i,
             cmderr_w1c_valid_i, cmderr_w1c_i, halted_i, going_i, done_i,
             exception_i,
      input  go_o, busy_o, cmderr_o, cmd_o, cmd_start_o
   );
endinterface

// File: rtl/dm_abstract_cmd_ctrl.sv
// Debug-module abstract command sequencer for one hart (Access Register only).
// Define DM_CMD_TIMEOUT_EN to build the GO/EXEC watchdog.
module dm_abstract_cmd_ctrl #(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = 11
) (
   input logic                   clk_i,
   input logic                   rst_i,
   dm_abstract_cmd_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      GO,
      EXEC
   } state_e;

   typedef enum logic [2:0] {
      CmdErrNone         = 3'd0,
      CmdErrBusy         = 3'd1,
      CmdErrNotSupported = 3'd2,
      CmdErrException    = 3'd3,
      CmdErrHaltResume   = 3'd4,
      CmdErrOther        = 3'd7
   } cmderr_e;

   if (2 ** CntWidth <= TimeoutCycles) begin : g_bad_cnt_width
      $error("CntWidth is too narrow to hold TimeoutCycles");
   end

   state_e      state_q, state_d;
   logic [2:0]  cmderr_q, cmderr_d;
   logic [31:0] cmd_q, cmd_d;
   logic        cmd_start_q, cmd_start_d;
   logic        clear;
   logic        trigger;
   logic        timeout;
   cmderr_e     eval_err;
   cmderr_e     set_err;
   logic [7:0]  ev_cmdtype;
   logic [2:0]  ev_aarsize;
   logic        ev_postexec;
   logic        ev_transfer;
   logic [15:0] ev_regno;

   assign clear   = rst_i | ~bus.dmactive_i;
   assign trigger = bus.cmd_valid_i | bus.autoexec_i;

   // A fresh Command write is evaluated directly; autoexec re-evaluates the latched word.
   always_comb begin
      ev_cmdtype  = bus.cmd_valid_i ? bus.cmd_i[31:24] : cmd_q[31:24];
      ev_aarsize  = bus.cmd_valid_i ? bus.cmd_i[22:20] : cmd_q[22:20];
      ev_postexec = bus.cmd_valid_i ? bus.cmd_i[18]    : cmd_q[18];
      ev_transfer = bus.cmd_valid_i ? bus.cmd_i[17]    : cmd_q[17];
      ev_regno    = bus.cmd_valid_i ? bus.cmd_i[15:0]  : cmd_q[15:0];
      eval_err    = CmdErrNone;
      if (ev_cmdtype != 8'h00) begin
         eval_err = CmdErrNotSupported;
      end else if (ev_transfer && !(ev_aarsize == 3'd2 || ev_aarsize == 3'd3)) begin
         eval_err = CmdErrNotSupported;
      end else if (ev_transfer && (ev_regno > 16'h101F)) begin
         eval_err = CmdErrNotSupported;
      end else if (!bus.halted_i) begin
         eval_err = CmdErrHaltResume;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmderr_d    = cmderr_q;
      cmd_d       = cmd_q;
      cmd_start_d = 1'b0;
      set_err     = CmdErrNone;

      unique case (state_q)
         IDLE: begin
            if (trigger && (cmderr_q == CmdErrNone)) begin
               if (bus.cmd_valid_i) begin
                  cmd_d = bus.cmd_i;
               end
               if (eval_err != CmdErrNone) begin
                  set_err = eval_err;
               end else begin
                  cmd_start_d = 1'b1;
                  if (ev_transfer || ev_postexec) begin
                     state_d = GO;
                  end
               end
            end
         end
         GO: begin
            if (timeout) begin
               state_d = IDLE;
               set_err = CmdErrOther;
            end else if (bus.going_i) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (bus.exception_i) begin
               state_d = IDLE;
               set_err = CmdErrException;
            end else if (bus.done_i) begin
               state_d = IDLE;
            end else if (timeout) begin
               state_d = IDLE;
               set_err = CmdErrOther;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && (set_err == CmdErrNone) &&
          (trigger || bus.busy_access_i)) begin
         set_err = CmdErrBusy;
      end

      // First error sticks; a same-cycle set beats W1C, and W1C is dropped while busy.
      if (set_err != CmdErrNone) begin
         if (cmderr_q == CmdErrNone) begin
            cmderr_d = set_err;
         end
      end else if (bus.cmderr_w1c_valid_i && (state_q == IDLE)) begin
         cmderr_d = cmderr_q & ~bus.cmderr_w1c_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         state_q     <= IDLE;
         cmderr_q    <= CmdErrNone;
         cmd_q       <= 32'h0;
         cmd_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmderr_q    <= cmderr_d;
         cmd_q       <= cmd_d;
         cmd_start_q <= cmd_start_d;
      end
   end

`ifdef DM_CMD_TIMEOUT_EN
   localparam logic [CntWidth-1:0] WdogLast = CntWidth'(TimeoutCycles - 1);

   logic [CntWidth-1:0] wdog_q, wdog_d;

   assign timeout = (state_q != IDLE) && (wdog_q == WdogLast);

   // Restart on every GO entry so each command gets the full budget.
   always_comb begin
      wdog_d = wdog_q;
      if ((state_q == IDLE) && (state_d == GO)) begin
         wdog_d = '0;
      end else if (state_q != IDLE) begin
         wdog_d = wdog_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign bus.go_o        = (state_q == GO);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.cmderr_o    = cmderr_q;
   assign bus.cmd_o       = cmd_q;
   assign bus.cmd_start_o = cmd_start_q;

endmodule

// File: tb/tb_dm_abstract_cmd_ctrl.sv
// Self-checking bench for dm_abstract_cmd_ctrl: vector table, directed
// corner sequences and randomized traffic against a command-level model.
module tb_dm_abstract_cmd_ctrl;

`ifdef DM_CMD_TIMEOUT_EN
   localparam int unsigned TimeoutTb    = 16;
   localparam bit          TimeoutModel = 1'b1;
`else
   localparam int unsigned TimeoutTb    = 1024;
   localparam bit          TimeoutModel = 1'b0;
`endif

   typedef struct packed {
      logic        rst;
      logic        dmactive;
      logic        cmd_valid;
      logic [31:0] cmd;
      logic        autoexec;
      logic        busy_access;
      logic        w1c_valid;
      logic [2:0]  w1c;
      logic        halted;
      logic        going;
      logic        done;
      logic        exception;
   } stim_t;

   typedef struct packed {
      logic [31:0] cmd;
      logic        halted;
      logic [2:0]  exp_err;
      logic        exp_start;
      logic        exp_go;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_i;
   int   tests = 0;
   int   fails = 0;

   // Reference model: an outstanding command, whether the hart took it, and abstractcs.
   bit          m_active;
   bit          m_taken;
   logic [2:0]  m_err;
   logic [31:0] m_cmd;
   bit          m_start;
   int          m_wd;

   always #5 clk_i = ~clk_i;

   dm_abstract_cmd_ctrl_if bus_if ();

   dm_abstract_cmd_ctrl #(
      .TimeoutCycles(TimeoutTb),
      .CntWidth     (11)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus_if.slave)
   );

   function automatic int judge(input logic [31:0] c, input logic halted);
      if (c[31:24] != 8'h00) return 2;
      if (c[17] && !(c[22:20] == 3'd2 || c[22:20] == 3'd3)) return 2;
      if (c[17] && (c[15:0] > 16'h101F)) return 2;
      if (!halted) return 4;
      return 0;
   endfunction

   task automatic modelStep(input stim_t s);
      int code;
      bit was_busy;
      bit trig;
      code     = 0;
      was_busy = m_active;
      trig     = s.cmd_valid || s.autoexec;
      if (s.rst || !s.dmactive) begin
         m_active = 0;
         m_taken  = 0;
         m_err    = 3'd0;
         m_cmd    = 32'h0;
         m_start  = 0;
         m_wd     = 0;
         return;
      end
      m_start = 0;
      if (!was_busy) begin
         if (trig && m_err == 3'd0) begin
            if (s.cmd_valid) m_cmd = s.cmd;
            code = judge(m_cmd, s.halted);
            if (code == 0) begin
               m_start = 1;
               if (m_cmd[17] || m_cmd[18]) begin
                  m_active = 1;
                  m_taken  = 0;
                  m_wd     = 0;
               end
            end
         end
      end else begin
         if (m_taken && s.exception) begin
            code     = 3;
            m_active = 0;
         end else if (m_taken && s.done) begin
            m_active = 0;
         end else if (TimeoutModel && m_wd == int'(TimeoutTb) - 1) begin
            code     = 7;
            m_active = 0;
         end else if (!m_taken && s.going) begin
            m_taken = 1;
         end
         m_wd++;
         if (code == 0 && (trig || s.busy_access)) code = 1;
      end
      if (code != 0) begin
         if (m_err == 3'd0) m_err = 3'(code);
      end else if (s.w1c_valid && !was_busy) begin
         m_err = m_err & ~s.w1c;
      end
   endtask

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkEq("model_go",     32'(bus_if.go_o),        32'(m_active && !m_taken));
      checkEq("model_busy",   32'(bus_if.busy_o),      32'(m_active));
      checkEq("model_cmderr", 32'(bus_if.cmderr_o),    32'(m_err));
      checkEq("model_cmd",    bus_if.cmd_o,            m_cmd);
      checkEq("model_start",  32'(bus_if.cmd_start_o), 32'(m_start));
   endtask

   task automatic applyStimulus(input stim_t s);
      rst_i                     = s.rst;
      bus_if.dmactive_i         = s.dmactive;
      bus_if.cmd_valid_i        = s.cmd_valid;
      bus_if.cmd_i              = s.cmd;
      bus_if.autoexec_i         = s.autoexec;
      bus_if.busy_access_i      = s.busy_access;
      bus_if.cmderr_w1c_valid_i = s.w1c_valid;
      bus_if.cmderr_w1c_i       = s.w1c;
      bus_if.halted_i           = s.halted;
      bus_if.going_i            = s.going;
      bus_if.done_i             = s.done;
      bus_if.exception_i        = s.exception;
      @(posedge clk_i);
      modelStep(s);
      #1;
      checkOutput();
   endtask

   function automatic stim_t quietStim();
      stim_t s;
      s          = '0;
      s.dmactive = 1'b1;
      s.halted   = 1'b1;
      return s;
   endfunction

   function automatic stim_t cmdStim(input logic [31:0] c);
      stim_t s;
      s           = quietStim();
      s.cmd_valid = 1'b1;
      s.cmd       = c;
      return s;
   endfunction

   function automatic logic [31:0] randCmd();
      logic [7:0]  ty;
      logic [2:0]  sz;
      logic [15:0] r;
      ty = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      sz = 3'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
         0:       r = 16'($urandom_range(0, 32'h0FFF));
         1:       r = 16'($urandom_range(32'h1000, 32'h101F));
         2:       r = 16'($urandom_range(32'h1020, 32'hFFFF));
         default: r = 16'($urandom());
      endcase
      return {ty, 1'b0, sz, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), r};
   endfunction

   initial begin
      vec_t  vecs[13];
      stim_t s;

      // {cmd, halted, expected cmderr, expected cmd_start, expected go}
      vecs[0]  = '{32'h0023_1008, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[1]  = '{32'h0240_1000, 1'b1, 3'd2, 1'b0, 1'b0};
      vecs[2]  = '{32'h0100_0000, 1'b1, 3'd2, 1'b0, 1'b0};
      vecs[3]  = '{32'h0023_1008, 1'b0, 3'd4, 1'b0, 1'b0};
      vecs[4]  = '{32'h0022_1000, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[5]  = '{32'h0033_101F, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[6]  = '{32'h0022_1020, 1'b1, 3'd2, 1'b0, 1'b0};
      vecs[7]  = '{32'h0000_0000, 1'b1, 3'd0, 1'b1, 1'b0};
      vecs[8]  = '{32'h0004_0000, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[9]  = '{32'h0012_1000, 1'b1, 3'd2, 1'b0, 1'b0};
      vecs[10] = '{32'h0022_0FFF, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[11] = '{32'h0010_5000, 1'b1, 3'd0, 1'b1, 1'b0};
      vecs[12] = '{32'h0000_0000, 1'b0, 3'd4, 1'b0, 1'b0};

      // Reset state
      s     = quietStim();
      s.rst = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      checkEq("reset_go",     32'(bus_if.go_o),        32'd0);
      checkEq("reset_busy",   32'(bus_if.busy_o),      32'd0);
      checkEq("reset_cmderr", 32'(bus_if.cmderr_o),    32'd0);
      checkEq("reset_cmd",    bus_if.cmd_o,            32'd0);
      checkEq("reset_start",  32'(bus_if.cmd_start_o), 32'd0);

      // Single-command evaluation from a clean IDLE
      for (int i = 0; i < 13; i++) begin
         s          = quietStim();
         s.dmactive = 1'b0;
         applyStimulus(s);
         s        = cmdStim(vecs[i].cmd);
         s.halted = vecs[i].halted;
         applyStimulus(s);
         checkEq($sformatf("vec%0d_cmderr", i), 32'(bus_if.cmderr_o),    32'(vecs[i].exp_err));
         checkEq($sformatf("vec%0d_start", i),  32'(bus_if.cmd_start_o), 32'(vecs[i].exp_start));
         checkEq($sformatf("vec%0d_go", i),     32'(bus_if.go_o),        32'(vecs[i].exp_go));
         checkEq($sformatf("vec%0d_busy", i),   32'(bus_if.busy_o),      32'(vecs[i].exp_go));
         checkEq($sformatf("vec%0d_cmd", i),    bus_if.cmd_o,            vecs[i].cmd);
      end

      // Accepted GPR write through the full go/going/done handshake
      s          = quietStim();
      s.dmactive = 1'b0;
      applyStimulus(s);
      applyStimulus(cmdStim(32'h0023_1008));
      checkEq("gpr_go",    32'(bus_if.go_o),        32'd1);
      checkEq("gpr_busy",  32'(bus_if.busy_o),      32'd1);
      checkEq("gpr_start", 32'(bus_if.cmd_start_o), 32'd1);
      applyStimulus(quietStim());
      checkEq("gpr_start_pulse", 32'(bus_if.cmd_start_o), 32'd0);
      applyStimulus(quietStim());
      s       = quietStim();
      s.going = 1'b1;
      applyStimulus(s);
      checkEq("gpr_going_go",   32'(bus_if.go_o),   32'd0);
      checkEq("gpr_going_busy", 32'(bus_if.busy_o), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(quietStim());
      s      = quietStim();
      s.done = 1'b1;
      applyStimulus(s);
      checkEq("gpr_done_busy",   32'(bus_if.busy_o),   32'd0);
      checkEq("gpr_done_cmderr", 32'(bus_if.cmderr_o), 32'd0);

      // Busy error during EXEC, W1C ignored while busy, then cleared once idle
      applyStimulus(cmdStim(32'h0023_1008));
      s       = quietStim();
      s.going = 1'b1;
      applyStimulus(s);
      applyStimulus(cmdStim(32'h0022_1000));
      checkEq("busy_cmderr", 32'(bus_if.cmderr_o), 32'd1);
      checkEq("busy_cmd",    bus_if.cmd_o,          32'h0023_1008);
      checkEq("busy_still",  32'(bus_if.busy_o),   32'd1);
      s             = quietStim();
      s.w1c_valid   = 1'b1;
      s.w1c         = 3'b111;
      s.busy_access = 1'b1;
      applyStimulus(s);
      checkEq("busy_w1c_ignored", 32'(bus_if.cmderr_o), 32'd1);
      s      = quietStim();
      s.done = 1'b1;
      applyStimulus(s);
      checkEq("busy_done", 32'(bus_if.busy_o), 32'd0);
      s           = quietStim();
      s.w1c_valid = 1'b1;
      s.w1c       = 3'b001;
      applyStimulus(s);
      checkEq("busy_w1c_clear", 32'(bus_if.cmderr_o), 32'd0);

      // Exception beats done; the error then blocks new commands
      applyStimulus(cmdStim(32'h0023_1008));
      s       = quietStim();
      s.going = 1'b1;
      applyStimulus(s);
      s           = quietStim();
      s.exception = 1'b1;
      s.done      = 1'b1;
      applyStimulus(s);
      checkEq("exc_cmderr", 32'(bus_if.cmderr_o), 32'd3);
      checkEq("exc_busy",   32'(bus_if.busy_o),   32'd0);
      applyStimulus(cmdStim(32'h0022_1000));
      checkEq("exc_block_go",    32'(bus_if.go_o),        32'd0);
      checkEq("exc_block_start", 32'(bus_if.cmd_start_o), 32'd0);
      checkEq("exc_block_cmd",   bus_if.cmd_o,            32'h0023_1008);
      s           = quietStim();
      s.w1c_valid = 1'b1;
      s.w1c       = 3'b011;
      applyStimulus(s);
      checkEq("exc_w1c", 32'(bus_if.cmderr_o), 32'd0);

      // Autoexec re-issue, then dmactive drop while in GO
      s          = quietStim();
      s.autoexec = 1'b1;
      applyStimulus(s);
      checkEq("auto_start", 32'(bus_if.cmd_start_o), 32'd1);
      checkEq("auto_cmd",   bus_if.cmd_o,            32'h0023_1008);
      checkEq("auto_go",    32'(bus_if.go_o),        32'd1);
      s       = quietStim();
      s.going = 1'b1;
      applyStimulus(s);
      s      = quietStim();
      s.done = 1'b1;
      applyStimulus(s);
      applyStimulus(cmdStim(32'h0023_1008));
      s          = quietStim();
      s.dmactive = 1'b0;
      applyStimulus(s);
      checkEq("clear_go",     32'(bus_if.go_o),     32'd0);
      checkEq("clear_busy",   32'(bus_if.busy_o),   32'd0);
      checkEq("clear_cmderr", 32'(bus_if.cmderr_o), 32'd0);
      s           = quietStim();
      s.done      = 1'b1;
      s.exception = 1'b1;
      applyStimulus(s);
      checkEq("stray_done_busy",   32'(bus_if.busy_o),   32'd0);
      checkEq("stray_done_cmderr", 32'(bus_if.cmderr_o), 32'd0);

      // Hart never answers go
      applyStimulus(cmdStim(32'h0023_1008));
`ifdef DM_CMD_TIMEOUT_EN
      for (int i = 0; i < 15; i++) applyStimulus(quietStim());
      checkEq("wdog_before_busy", 32'(bus_if.busy_o), 32'd1);
      applyStimulus(quietStim());
      checkEq("wdog_busy",   32'(bus_if.busy_o),   32'd0);
      checkEq("wdog_cmderr", 32'(bus_if.cmderr_o), 32'd7);
`else
      for (int i = 0; i < 1000; i++) applyStimulus(quietStim());
      checkEq("nowdog_busy", 32'(bus_if.busy_o), 32'd1);
      checkEq("nowdog_go",   32'(bus_if.go_o),   32'd1);
`endif

      // Randomized traffic against the model
      s          = quietStim();
      s.dmactive = 1'b0;
      applyStimulus(s);
      for (int n = 0; n < 3000; n++) begin
         s             = quietStim();
         s.rst         = ($urandom_range(0, 199) == 0);
         s.dmactive    = ($urandom_range(0, 199) != 0);
         s.cmd_valid   = ($urandom_range(0, 99) < 12);
         s.cmd         = randCmd();
         s.autoexec    = ($urandom_range(0, 99) < 5);
         s.busy_access = ($urandom_range(0, 99) < 4);
         s.w1c_valid   = ($urandom_range(0, 99) < 10);
         s.w1c         = 3'($urandom_range(0, 7));
         s.halted      = ($urandom_range(0, 99) < 90);
         s.going       = ($urandom_range(0, 99) < 30);
         s.done        = ($urandom_range(0, 99) < 20);
         s.exception   = ($urandom_range(0, 99) < 5);
         applyStimulus(s);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
